// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the requester-side and RAM-side signals of the
// shared RAM port arbiter.
//   slave  : view taken by the arbiter (requests and RAM status in,
//            grants, wait strobes and RAM commands out)
//   master : view taken by the requesters / RAM model driving the arbiter
// Signals:
//   req_ren/req_wen/req_burst [NREQ]   per-requester request, burst = 2 words
//   req_addr/req_store [NREQ][32]      base word address, live write data
//   req_wait [NREQ]                    low for the cycle a beat completes
//   req_load [32], req_beat            read data and beat index of owner
//   grant_valid, grant_id              transfer in progress, current owner
//   err                                one-cycle abort pulse
//   ramREN/ramWEN/ramaddr/ramstore     RAM command
//   ramload [32], ramstate [2]         RAM response
interface ram_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]                req_ren;
  logic [NREQ-1:0]                req_wen;
  logic [NREQ-1:0]                req_burst;
  logic [NREQ-1:0][31:0]          req_addr;
  logic [NREQ-1:0][31:0]          req_store;
  logic [NREQ-1:0]                req_wait;
  logic [31:0]                    req_load;
  logic                           req_beat;
  logic                           grant_valid;
  logic [$clog2(NREQ)-1:0]        grant_id;
  logic                           err;
  logic                           ramREN;
  logic                           ramWEN;
  logic [31:0]                    ramaddr;
  logic [31:0]                    ramstore;
  logic [31:0]                    ramload;
  logic [1:0]                     ramstate;

  modport slave (
    input  req_ren, req_wen, req_burst, req_addr, req_store,
    input  ramload, ramstate,
    output req_wait, req_load, req_beat, grant_valid, grant_id, err,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req_ren, req_wen, req_burst, req_addr, req_store,
    output ramload, ramstate,
    input  req_wait, req_load, req_beat, grant_valid, grant_id, err,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer sharing one RAM port among
// NREQ requesters. Each grant moves one or two words; the second-beat address
// is generated here. A per-beat stall timeout and RAM ERROR both abort the
// transfer with a one-cycle err pulse.
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   bus   ram_arbiter_if.slave (requester and RAM signals, see interface)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick next pending requester round-robin from rr_ptr
// XFER  | owner latched; drive RAM for current beat until ACCESS/abort
module ram_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  ram_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            op_q, op_d;        // 1 = write
  logic            burst_q, burst_d;
  logic            beat_q, beat_d;
  logic [31:0]     base_q, base_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;

  logic [NREQ-1:0] pending;
  logic            pick_valid;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  next_ptr;
  logic            owner_active;
  logic            done_c;
  logic            err_c;

  assign pending      = bus.req_ren | bus.req_wen;
  assign owner_active = bus.req_ren[owner_q] | bus.req_wen[owner_q];
  assign next_ptr     = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

  // First pending index at or after rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (!pick_valid && pending[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    base_d   = base_q;
    tcnt_d   = tcnt_q;

    done_c          = 1'b0;
    err_c           = 1'b0;
    bus.req_load    = '0;
    bus.req_beat    = 1'b0;
    bus.grant_valid = 1'b0;
    bus.grant_id    = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_id;
          op_d    = bus.req_wen[pick_id];
          burst_d = bus.req_burst[pick_id];
          base_d  = bus.req_addr[pick_id] & 32'hFFFF_FFFC;
          beat_d  = 1'b0;
          tcnt_d  = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        bus.grant_valid = 1'b1;
        bus.grant_id    = owner_q;
        bus.req_beat    = beat_q;
        bus.req_load    = bus.ramload;
        bus.ramaddr     = base_q + {29'd0, beat_q, 2'b00};
        bus.ramstore    = bus.req_store[owner_q];

        if (!owner_active) begin
          // Owner withdrew: silent abort, RAM command suppressed this cycle.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          bus.ramREN = !op_q;
          bus.ramWEN = op_q;
          if (bus.ramstate == RAM_ACCESS) begin
            done_c = 1'b1;
            if (beat_q == burst_q) begin
              state_d  = IDLE;
              rr_ptr_d = next_ptr;
            end else begin
              beat_d = 1'b1;
              tcnt_d = '0;
            end
          end else if (bus.ramstate == RAM_ERROR) begin
            done_c   = 1'b1;
            err_c    = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else if (tcnt_q == TCNT_LAST) begin
            done_c   = 1'b1;
            err_c    = 1'b1;
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A beat cannot complete in a reset cycle, so the strobes are masked.
  assign bus.req_wait = (done_c && !RST) ? ~(NREQ'(1) << owner_q) : '1;
  assign bus.err      = err_c && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= 1'b0;
      burst_q  <= 1'b0;
      beat_q   <= 1'b0;
      base_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();

  ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one transfer in flight at most, described by who owns
  // it, which word is being moved and how long the current word has stalled.
  bit          m_busy  = 1'b0;
  bit          m_op;
  bit          m_burst;
  int          m_own   = 0;
  int          m_rr    = 0;
  int          m_beat  = 0;
  int          m_stall = 0;
  logic [31:0] m_base;

  int gl[$];
  int rr_exp[4] = '{0, 1, 2, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    logic [NREQ-1:0] e_wait;
    logic            e_err, e_ren, e_wen, e_gv, e_beat, alive;
    logic [1:0]      e_gid;
    logic [31:0]     e_addr, e_store, e_load;
    e_wait = '1; e_err = 0; e_ren = 0; e_wen = 0; e_gv = 0; e_beat = 0;
    e_gid = 0; e_addr = 0; e_store = 0; e_load = 0;
    if (m_busy) begin
      alive   = bus.req_ren[m_own] | bus.req_wen[m_own];
      e_gv    = 1'b1;
      e_gid   = 2'(m_own);
      e_beat  = (m_beat == 1);
      e_addr  = m_base + 32'(m_beat) * 32'd4;
      e_store = bus.req_store[m_own];
      e_load  = bus.ramload;
      if (alive) begin
        e_ren = !m_op;
        e_wen = m_op;
        if (!RST) begin
          if (bus.ramstate == S_ACCESS) begin
            e_wait[m_own] = 1'b0;
          end else if (bus.ramstate == S_ERROR || m_stall == TIMEOUT - 1) begin
            e_wait[m_own] = 1'b0;
            e_err = 1'b1;
          end
        end
      end
    end
    check("req_wait",    32'(bus.req_wait),    32'(e_wait));
    check("err",         32'(bus.err),         32'(e_err));
    check("ramREN",      32'(bus.ramREN),      32'(e_ren));
    check("ramWEN",      32'(bus.ramWEN),      32'(e_wen));
    check("grant_valid", 32'(bus.grant_valid), 32'(e_gv));
    check("grant_id",    32'(bus.grant_id),    32'(e_gid));
    check("req_beat",    32'(bus.req_beat),    32'(e_beat));
    check("ramaddr",     bus.ramaddr,          e_addr);
    check("ramstore",    bus.ramstore,         e_store);
    check("req_load",    bus.req_load,         e_load);
  endtask

  task automatic model_finish();
    m_busy = 1'b0;
    m_rr   = (m_own + 1) % NREQ;
  endtask

  task automatic model_advance();
    if (RST) begin
      m_busy = 1'b0;
      m_rr   = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (!m_busy && (bus.req_ren[c] || bus.req_wen[c])) begin
          m_busy  = 1'b1;
          m_own   = c;
          m_op    = bus.req_wen[c];
          m_burst = bus.req_burst[c];
          m_base  = {bus.req_addr[c][31:2], 2'b00};
          m_beat  = 0;
          m_stall = 0;
        end
      end
    end else if (!(bus.req_ren[m_own] || bus.req_wen[m_own])) begin
      model_finish();
    end else if (bus.ramstate == S_ACCESS) begin
      if (m_beat == 1 || !m_burst) model_finish();
      else begin
        m_beat  = 1;
        m_stall = 0;
      end
    end else if (bus.ramstate == S_ERROR || m_stall == TIMEOUT - 1) begin
      model_finish();
    end else begin
      m_stall++;
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic tick();
    settle();
    clk_edge();
  endtask

  task automatic set_req(input int i, input bit ren, input bit wen, input bit burst,
                         input logic [31:0] addr);
    bus.req_ren[i]   = ren;
    bus.req_wen[i]   = wen;
    bus.req_burst[i] = burst;
    bus.req_addr[i]  = addr;
  endtask

  task automatic drop_all();
    bus.req_ren = '0;
    bus.req_wen = '0;
    bus.req_burst = '0;
  endtask

  initial begin
    logic [NREQ-1:0] last_wait;
    logic            prev_gv;

    RST = 1'b1;
    drop_all();
    bus.req_addr  = '0;
    bus.req_store = '0;
    bus.ramload   = '0;
    bus.ramstate  = S_FREE;
    clk_edge();
    tick();
    RST = 1'b0;
    settle();
    check("rst_wait", 32'(bus.req_wait), 32'h7);
    clk_edge();

    // Single read from requester 1.
    set_req(1, 1, 0, 0, 32'h0000_0104);
    bus.ramstate = S_BUSY;
    tick();
    settle();
    check("rd_addr", bus.ramaddr, 32'h104);
    check("rd_ren",  32'(bus.ramREN), 32'd1);
    clk_edge();
    tick();
    bus.ramstate = S_ACCESS;
    bus.ramload  = 32'hDEAD_BEEF;
    settle();
    check("rd_wait", 32'(bus.req_wait), 32'h5);
    check("rd_load", bus.req_load, 32'hDEAD_BEEF);
    clk_edge();
    // rr_ptr now 2: with 0 and 2 pending, 2 wins.
    set_req(1, 0, 0, 0, 32'h0);
    set_req(0, 1, 0, 0, 32'h10);
    set_req(2, 1, 0, 0, 32'h20);
    tick();
    settle();
    check("rr_after_rd", 32'(bus.grant_id), 32'd2);
    clk_edge();
    drop_all();
    bus.ramstate = S_FREE;
    tick();

    // Two-word write from requester 0, store data changes between beats.
    set_req(0, 0, 1, 1, 32'h0000_0202);
    bus.req_store[0] = 32'h0000_AAAA;
    tick();
    bus.ramstate = S_ACCESS;
    settle();
    check("bw_addr0",  bus.ramaddr, 32'h200);
    check("bw_data0",  bus.ramstore, 32'hAAAA);
    check("bw_wen",    32'(bus.ramWEN), 32'd1);
    check("bw_wait0",  32'(bus.req_wait), 32'h6);
    clk_edge();
    bus.req_store[0] = 32'h0000_BBBB;
    bus.ramstate = S_BUSY;
    settle();
    check("bw_addr1",  bus.ramaddr, 32'h204);
    check("bw_data1",  bus.ramstore, 32'hBBBB);
    check("bw_beat1",  32'(bus.req_beat), 32'd1);
    clk_edge();
    bus.ramstate = S_ACCESS;
    settle();
    check("bw_wait1",  32'(bus.req_wait), 32'h6);
    clk_edge();
    drop_all();
    bus.ramstate = S_FREE;
    tick();

    // Round robin from a fresh pointer.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 32'h1000 + 32'(i) * 32'h10);
    bus.ramstate = S_ACCESS;
    prev_gv = 1'b0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (bus.grant_valid && !prev_gv) gl.push_back(int'(bus.grant_id));
      prev_gv = bus.grant_valid;
      clk_edge();
    end
    check("rr_count", 32'(gl.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < gl.size()) check("rr_order", 32'(gl[k]), 32'(rr_exp[k]));
    drop_all();
    bus.ramstate = S_FREE;
    tick();
    tick();

    // Stall timeout on requester 1, then requester 2 is served.
    set_req(1, 1, 0, 0, 32'h3000);
    set_req(2, 1, 0, 0, 32'h3100);
    bus.ramstate = S_BUSY;
    tick();
    for (int c = 1; c <= TIMEOUT; c++) begin
      settle();
      check("to_err", 32'(bus.err), (c == TIMEOUT) ? 32'd1 : 32'd0);
      check("to_wait", 32'(bus.req_wait), (c == TIMEOUT) ? 32'h5 : 32'h7);
      clk_edge();
    end
    settle();
    check("to_bubble", 32'(bus.grant_valid), 32'd0);
    clk_edge();
    bus.ramstate = S_ACCESS;
    settle();
    check("to_next", 32'(bus.grant_id), 32'd2);
    clk_edge();
    drop_all();
    bus.ramstate = S_FREE;
    tick();

    // Owner withdraws mid-beat.
    set_req(0, 1, 0, 0, 32'h4000);
    bus.ramstate = S_BUSY;
    tick();
    tick();
    set_req(0, 0, 0, 0, 32'h4000);
    settle();
    check("ab_ren",  32'(bus.ramREN), 32'd0);
    check("ab_wait", 32'(bus.req_wait), 32'h7);
    check("ab_err",  32'(bus.err), 32'd0);
    clk_edge();
    tick();

    // RAM error on beat 0 of a burst.
    set_req(1, 1, 0, 1, 32'h300);
    bus.ramstate = S_ERROR;
    tick();
    settle();
    check("er_err",  32'(bus.err), 32'd1);
    check("er_wait", 32'(bus.req_wait), 32'h5);
    clk_edge();
    set_req(1, 0, 0, 0, 32'h300);
    bus.ramstate = S_FREE;
    settle();
    check("er_nobeat1", 32'(bus.grant_valid), 32'd0);
    clk_edge();

    // Reset during beat 1 of a burst owned by requester 2.
    set_req(1, 1, 0, 0, 32'h400);
    set_req(2, 1, 0, 1, 32'h500);
    tick();
    bus.ramstate = S_ACCESS;
    tick();
    RST = 1'b1;
    settle();
    check("rs_addr", bus.ramaddr, 32'h504);
    check("rs_wait", 32'(bus.req_wait), 32'h7);
    clk_edge();
    RST = 1'b0;
    settle();
    check("rs_ren",  32'(bus.ramREN), 32'd0);
    check("rs_gv",   32'(bus.grant_valid), 32'd0);
    clk_edge();
    settle();
    check("rs_first", 32'(bus.grant_id), 32'd1);
    clk_edge();
    drop_all();
    bus.ramstate = S_FREE;
    tick();

    // Randomized traffic against the model.
    last_wait = '1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int r;
      RST = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 15);
        if (!last_wait[i] && $urandom_range(0, 1) == 1) begin
          bus.req_ren[i] = 1'b0;
          bus.req_wen[i] = 1'b0;
        end else if (r == 0) begin
          bus.req_ren[i] = 1'b0;
          bus.req_wen[i] = 1'b0;
        end else if (r <= 3) begin
          bus.req_ren[i] = 1'($urandom_range(0, 1));
          bus.req_wen[i] = 1'($urandom_range(0, 1));
        end
        bus.req_burst[i] = 1'($urandom_range(0, 1));
        bus.req_addr[i]  = $urandom;
        bus.req_store[i] = $urandom;
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 4) ? S_ACCESS : (r < 8) ? S_BUSY : (r == 8) ? S_FREE : S_ERROR;
      bus.ramload  = $urandom;
      settle();
      last_wait = bus.req_wait;
      clk_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
